eth_phy_10g_rx_gearbox: RTL and testbench

Receive-side 64:66 gearbox for the 10GBASE-R PHY. It takes raw 64-bit SERDES words, one per clock, and emits aligned 66-bit blocks as a 2-bit sync header plus 64-bit payload, with a valid strobe. It sits directly upstream of `eth_phy_10g_rx`: it drives that block's `serdes_rx_data`/`serdes_rx_hdr` and consumes its `serdes_rx_bitslip` request to shift block alignment by one bit.

---
 rtl/eth_phy_10g_rx_gearbox.sv | 79 +++++++
 tb/tb_eth_phy_10g_rx_gearbox.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/eth_phy_10g_rx_gearbox.sv
// rtl/eth_phy_10g_rx_gearbox.sv - 10GBASE-R receive 64:66 gearbox with bitslip
module eth_phy_10g_rx_gearbox #(
  parameter int DATA_WIDTH  = 64,
  parameter int HDR_WIDTH   = 2,
  parameter bit BIT_REVERSE = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] serdes_rx_data_raw,
  input  logic                  serdes_rx_bitslip,
  output logic [DATA_WIDTH-1:0] serdes_rx_data,
  output logic [HDR_WIDTH-1:0]  serdes_rx_hdr,
  output logic                  serdes_rx_valid
);

  localparam int BLOCK_WIDTH = DATA_WIDTH + HDR_WIDTH;
  // Worst case holds 65 leftover bits plus a fresh 64-bit word.
  localparam int BUF_WIDTH   = 2 * BLOCK_WIDTH - 2;

  logic [BUF_WIDTH-1:0]  bit_buf;
  logic [6:0]            fill_count;

  logic [DATA_WIDTH-1:0] word;
  logic [BUF_WIDTH-1:0]  keep_mask;
  logic [BUF_WIDTH-1:0]  merged;
  logic [BUF_WIDTH-1:0]  slipped;
  logic [7:0]            fill_merged;
  logic [7:0]            fill_slipped;
  logic                  emit;

  // Optional per-word bit reversal so bit 0 is always the earliest bit on the wire.
  always_comb begin
    word = serdes_rx_data_raw;
    if (BIT_REVERSE) begin
      for (int i = 0; i < DATA_WIDTH; i++) begin
        word[i] = serdes_rx_data_raw[DATA_WIDTH-1-i];
      end
    end
  end

  // Append the new word above the valid bits, apply an optional one-bit slip, decide on a block.
  always_comb begin
    // Bits at or above the fill point are stale; mask them so a reset needs no buffer clear.
    keep_mask   = ~({BUF_WIDTH{1'b1}} << fill_count);
    merged      = (bit_buf & keep_mask)
                | ({{(BUF_WIDTH-DATA_WIDTH){1'b0}}, word} << fill_count);
    fill_merged = {1'b0, fill_count} + 8'(DATA_WIDTH);
    if (serdes_rx_bitslip) begin
      slipped      = merged >> 1;
      fill_slipped = fill_merged - 8'd1;
    end else begin
      slipped      = merged;
      fill_slipped = fill_merged;
    end
    emit = (fill_slipped >= 8'(BLOCK_WIDTH));
  end

  // Register the emitted block and retire its bits from the buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      fill_count      <= 7'd0;
      serdes_rx_valid <= 1'b0;
      serdes_rx_data  <= '0;
      serdes_rx_hdr   <= '0;
    end else begin
      serdes_rx_valid <= emit;
      if (emit) begin
        serdes_rx_hdr  <= slipped[HDR_WIDTH-1:0];
        serdes_rx_data <= slipped[BLOCK_WIDTH-1:HDR_WIDTH];
        bit_buf        <= slipped >> BLOCK_WIDTH;
        fill_count     <= 7'(fill_slipped - 8'(BLOCK_WIDTH));
      end else begin
        bit_buf        <= slipped;
        fill_count     <= fill_slipped[6:0];
      end
    end
  end

endmodule

// File: tb/tb_eth_phy_10g_rx_gearbox.sv
// tb/tb_eth_phy_10g_rx_gearbox.sv - self-checking bench for the 64:66 rx gearbox
module tb_eth_phy_10g_rx_gearbox;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [63:0] raw, raw_r;
  logic        slip;
  logic [63:0] data, data_r;
  logic [1:0]  hdr, hdr_r;
  logic        valid, valid_r;

  eth_phy_10g_rx_gearbox #(.DATA_WIDTH(64), .HDR_WIDTH(2), .BIT_REVERSE(1'b0)) dut (
    .clk(clk), .rst(rst), .serdes_rx_data_raw(raw), .serdes_rx_bitslip(slip),
    .serdes_rx_data(data), .serdes_rx_hdr(hdr), .serdes_rx_valid(valid));

  eth_phy_10g_rx_gearbox #(.DATA_WIDTH(64), .HDR_WIDTH(2), .BIT_REVERSE(1'b1)) dut_r (
    .clk(clk), .rst(rst), .serdes_rx_data_raw(raw_r), .serdes_rx_bitslip(slip),
    .serdes_rx_data(data_r), .serdes_rx_hdr(hdr_r), .serdes_rx_valid(valid_r));

  int errors = 0;
  int checks = 0;

  logic        bq[$];
  logic [65:0] sb[$];
  logic        exp_valid;

  typedef struct {
    int off;
    int slip_start;
    int slip_len;
    int ncyc;
    bit check_pre;
    int exp_first;
    int exp_nvalid;
    int exp_gaps;
    int exp_last;
    int idle_gap;
  } vec_t;

  vec_t vecs[3];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Word n of a stream of packed blocks (hdr 01, payload = block index) delayed by off junk bits.
  function automatic logic [63:0] gen_word(input int n, input int off);
    logic [63:0] w;
    logic [63:0] pl;
    longint      k;
    int          p;
    for (int j = 0; j < 64; j++) begin
      k = longint'(n) * 64 + j - off;
      if (k < 0) begin
        w[j] = 1'b0;
      end else begin
        pl = 64'(k / 66);
        p  = int'(k % 66);
        if (p == 0)      w[j] = 1'b1;
        else if (p == 1) w[j] = 1'b0;
        else             w[j] = pl[p-2];
      end
    end
    return w;
  endfunction

  task automatic do_reset();
    rst  = 1'b1;
    raw  = {$urandom, $urandom};
    raw_r = ~raw;
    slip = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_valid", valid, 0);
    check("rst_data", data, 0);
    check("rst_hdr", hdr, 0);
    check("rst_valid_rev", valid_r, 0);
    check("rst_data_rev", data_r, 0);
    check("rst_hdr_rev", hdr_r, 0);
    check("rst_fill", dut.fill_count, 0);
    rst = 1'b0;
    bq.delete();
    sb.delete();
    exp_valid = 1'b0;
  endtask

  task automatic cycle(input logic [63:0] w, input logic s);
    logic [65:0] blk;
    logic        dummy;
    raw   = w;
    raw_r = {<<{w}};
    slip  = s;
    for (int j = 0; j < 64; j++) bq.push_back(w[j]);
    if (s) dummy = bq.pop_front();
    if (bq.size() >= 66) begin
      for (int j = 0; j < 66; j++) blk[j] = bq.pop_front();
      sb.push_back(blk);
      exp_valid = 1'b1;
    end else begin
      exp_valid = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
    check("valid", valid, exp_valid);
    check("valid_rev", valid_r, exp_valid);
    if (exp_valid && sb.size() > 0) begin
      blk = sb.pop_front();
      check("block", {data, hdr}, blk);
      check("block_rev", {data_r, hdr_r}, blk);
    end
    check("fill_model", dut.fill_count, bq.size());
    check("fill_range", (dut.fill_count <= 7'd65), 1);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int          first;
    int          nvalid;
    int          gaps;
    int          prev_idle;
    int          k;
    logic [63:0] last;
    logic [63:0] last_any;
    bit          have_last;
    bit          good;
    first = -1; nvalid = 0; gaps = 0; prev_idle = -1;
    last = '0; last_any = '1; have_last = 1'b0;
    do_reset();
    for (int n = 0; n < v.ncyc; n++) begin
      cycle(gen_word(n, v.off),
            (v.slip_start >= 0 && n >= v.slip_start && n < v.slip_start + v.slip_len));
      k = n + 1;
      if (valid) begin
        nvalid++;
        if (first < 0) first = k;
        last_any = data;
        good = (v.slip_start < 0) || (v.check_pre && k <= v.slip_start)
            || (k >= v.slip_start + v.slip_len + 2);
        if (good) begin
          check($sformatf("v%0d_hdr_aligned", idx), hdr, 2'b01);
          if (have_last && data != last + 64'd1) gaps++;
          last = data;
          have_last = 1'b1;
        end
      end else begin
        if (v.idle_gap != 0 && prev_idle >= 0)
          check($sformatf("v%0d_idle_spacing", idx), k - prev_idle, v.idle_gap);
        prev_idle = k;
      end
    end
    check($sformatf("v%0d_first_valid", idx), first, v.exp_first);
    check($sformatf("v%0d_nvalid", idx), nvalid, v.exp_nvalid);
    check($sformatf("v%0d_gaps", idx), gaps, v.exp_gaps);
    check($sformatf("v%0d_last_payload", idx), last_any, v.exp_last);
    check($sformatf("v%0d_sb_empty", idx), sb.size(), 0);
  endtask

  initial begin
    rst = 1'b1; raw = '0; raw_r = '0; slip = 1'b0; exp_valid = 1'b0;

    //          off slip len ncyc pre first nvalid gaps last idle
    vecs[0] = '{0,  -1,  0,  330, 1'b1, 2, 320, 0, 319, 33};
    vecs[1] = '{1,  10,  1,  200, 1'b0, 2, 193, 0, 192, 0};
    vecs[2] = '{0,  20,  66, 330, 1'b1, 2, 319, 1, 319, 0};

    for (int i = 0; i < 3; i++) run_vec(i, vecs[i]);

    // Slip on a cycle where the fill count is 2.
    do_reset();
    for (int n = 0; n < 32; n++) cycle(gen_word(n, 0), 1'b0);
    check("lowfill_pre_fill", dut.fill_count, 2);
    cycle(gen_word(32, 0), 1'b1);
    check("lowfill_slip_valid", valid, 0);
    check("lowfill_slip_fill", dut.fill_count, 65);
    cycle(gen_word(33, 0), 1'b0);
    check("lowfill_next_valid", valid, 1);
    check("lowfill_next_fill", dut.fill_count, 63);

    // Reset in the middle of a running stream, then restart from block 0.
    do_reset();
    for (int n = 0; n < 50; n++) cycle(gen_word(n, 0), 1'b0);
    do_reset();
    cycle(gen_word(0, 0), 1'b0);
    check("restart_c0_valid", valid, 0);
    cycle(gen_word(1, 0), 1'b0);
    check("restart_c1_valid", valid, 1);
    check("restart_c1_hdr", hdr, 2'b01);
    check("restart_c1_data", data, 64'd0);
    cycle(gen_word(2, 0), 1'b0);
    check("restart_c2_data", data, 64'd1);
    check("restart_c2_hdr_rev", hdr_r, 2'b01);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
